// File: rtl/matmul_io_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matmul_io_ctrl
// Description : Byte-serial host front end for a 3x3 8-bit matrix multiply
//               core. Collects 18 operand bytes (A then B, element 0 first),
//               pulses start to the core, waits for the core's done pulse,
//               captures the 3x3 16-bit result and streams it back to the
//               host as 18 bytes (low byte of each element first). A WAIT
//               watchdog drops the frame and raises a sticky err flag if the
//               core never answers.
// Ports       : clk, rst        - clock, asynchronous active-high reset
//               in_data/valid   - host operand byte stream (in_ready = accept)
//               out_data/valid  - result byte stream (out_ready = host accept)
//               A_flat, B_flat  - operand matrices to core, 8 bits/element
//               start           - START_LEN-cycle start pulse to core
//               C_flat, done    - result matrix and completion from core
//               busy            - frame in progress
//               err             - sticky WAIT timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_io_ctrl #(
    parameter int START_LEN    = 2,
    parameter int WAIT_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [71:0]  A_flat,
    output logic [71:0]  B_flat,
    output logic         start,
    input  logic [143:0] C_flat,
    input  logic         done,
    output logic         busy,
    output logic         err
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] C_ST_LOAD  = 2'd0;
    localparam logic [1:0] C_ST_START = 2'd1;
    localparam logic [1:0] C_ST_WAIT  = 2'd2;
    localparam logic [1:0] C_ST_SEND  = 2'd3;

    localparam logic [4:0] C_LAST_BYTE = 5'd17;

    // Counters only ever need to reach LEN-1, so $clog2(LEN) bits suffice.
    localparam int SCW = (START_LEN    > 1) ? $clog2(START_LEN)    : 1;
    localparam int WCW = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

    localparam logic [SCW-1:0] C_START_LAST = SCW'(START_LEN - 1);
    localparam logic [WCW-1:0] C_WAIT_LAST  = WCW'(WAIT_TIMEOUT - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]     state_q, state_d;
    logic [4:0]     k_q;            // input byte index
    logic [4:0]     j_q;            // output byte index
    logic [SCW-1:0] start_cnt_q;
    logic [WCW-1:0] wait_cnt_q;
    logic           done_seen_q;
    logic [71:0]    a_q;
    logic [71:0]    b_q;
    logic [143:0]   result_q;
    logic           err_q;

    // ------------------------------------------------------------------
    // Handshake / event decode
    // ------------------------------------------------------------------
    logic w_in_acc;
    logic w_out_acc;
    logic w_last_in;
    logic w_last_out;
    logic w_start_last;
    logic w_capture;
    logic w_timeout;

    assign w_in_acc     = (state_q == C_ST_LOAD) && in_valid;
    assign w_out_acc    = (state_q == C_ST_SEND) && out_ready;
    assign w_last_in    = w_in_acc  && (k_q == C_LAST_BYTE);
    assign w_last_out   = w_out_acc && (j_q == C_LAST_BYTE);
    assign w_start_last = (state_q == C_ST_START) && (start_cnt_q == C_START_LAST);
    // Capture on the falling side of done, so the core's C_flat has been
    // stable for at least the whole done-high cycle.
    assign w_capture    = (state_q == C_ST_WAIT) && done_seen_q && !done;
    // A capture on the final allowed cycle still wins over the timeout.
    assign w_timeout    = (state_q == C_ST_WAIT) && !w_capture
                          && (wait_cnt_q == C_WAIT_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= C_ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_LOAD:  if (w_last_in)    state_d = C_ST_START;
            C_ST_START: if (w_start_last) state_d = C_ST_WAIT;
            C_ST_WAIT: begin
                if (w_capture)      state_d = C_ST_SEND;
                else if (w_timeout) state_d = C_ST_LOAD;
            end
            C_ST_SEND:  if (w_last_out)   state_d = C_ST_LOAD;
            default:                      state_d = C_ST_LOAD;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    logic [7:0] w_out_byte;

    always_comb begin
        w_out_byte = 8'h00;
        for (int i = 0; i < 18; i++) begin
            if (j_q == 5'(i)) begin
                w_out_byte = result_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        start     = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        case (state_q)
            C_ST_LOAD:  in_ready = 1'b1;
            C_ST_START: start    = 1'b1;
            C_ST_SEND: begin
                out_valid = 1'b1;
                out_data  = w_out_byte;
            end
            default: ;
        endcase
        busy = (state_q != C_ST_LOAD) || (k_q != 5'd0);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q         <= 5'd0;
            j_q         <= 5'd0;
            start_cnt_q <= '0;
            wait_cnt_q  <= '0;
            done_seen_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            // Operand collection: bytes 0-8 -> A, bytes 9-17 -> B.
            if (w_in_acc) begin
                k_q <= w_last_in ? 5'd0 : (k_q + 5'd1);
                for (int i = 0; i < 9; i++) begin
                    if (k_q == 5'(i)) begin
                        a_q[8*i +: 8] <= in_data;
                    end
                    if (k_q == 5'(i + 9)) begin
                        b_q[8*i +: 8] <= in_data;
                    end
                end
            end

            // Result streaming index.
            if (w_out_acc) begin
                j_q <= w_last_out ? 5'd0 : (j_q + 5'd1);
            end

            // Start pulse length counter; idles at zero outside START.
            if (state_q == C_ST_START) begin
                start_cnt_q <= start_cnt_q + 1'b1;
            end else begin
                start_cnt_q <= '0;
            end

            // WAIT watchdog; the timeout decode leaves WAIT before it wraps.
            if (state_q == C_ST_WAIT) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end else begin
                wait_cnt_q <= '0;
            end

            if (state_q == C_ST_WAIT) begin
                if (done) begin
                    done_seen_q <= 1'b1;
                end
            end else begin
                done_seen_q <= 1'b0;
            end

            if (w_capture) begin
                result_q <= C_flat;
            end

            // Sticky until the first byte of the following frame is taken.
            if (w_timeout) begin
                err_q <= 1'b1;
            end else if (w_in_acc && (k_q == 5'd0)) begin
                err_q <= 1'b0;
            end
        end
    end

    assign A_flat = a_q;
    assign B_flat = b_q;
    assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_io_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_matmul_io_ctrl
// Description : Directed self-checking bench for matmul_io_ctrl with a
//               behavioural 3x3 multiply core stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matmul_io_ctrl;

    typedef logic [7:0] frame_t [18];

    logic         clk;
    logic         rst;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_data;
    logic         out_valid;
    logic         out_ready;
    logic [71:0]  A_flat;
    logic [71:0]  B_flat;
    logic         start;
    logic [143:0] C_flat;
    logic         done;
    logic         busy;
    logic         err;

    int n_err = 0;
    int n_chk = 0;

    bit core_hang = 1'b0;
    int start_run = 0;
    int last_start_len = 0;
    bit stub_armed = 1'b0;
    int stub_dly = 0;

    matmul_io_ctrl #(
        .START_LEN    (2),
        .WAIT_TIMEOUT (255)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .A_flat    (A_flat),
        .B_flat    (B_flat),
        .start     (start),
        .C_flat    (C_flat),
        .done      (done),
        .busy      (busy),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Row-major 3x3 product with 16-bit wrap, as the real core computes it.
    function automatic logic [143:0] mm(input logic [71:0] a, input logic [71:0] b);
        logic [143:0] c;
        logic [15:0]  s;
        c = '0;
        for (int i = 0; i < 3; i++) begin
            for (int jj = 0; jj < 3; jj++) begin
                s = 16'h0000;
                for (int m = 0; m < 3; m++) begin
                    s = s + 16'(a[8*(3*i+m) +: 8]) * 16'(b[8*(3*m+jj) +: 8]);
                end
                c[16*(3*i+jj) +: 16] = s;
            end
        end
        return c;
    endfunction

    // Core stub: three cycles after start falls, present C and pulse done.
    always @(negedge clk) begin
        if (rst) begin
            stub_armed = 1'b0;
            stub_dly   = 0;
            done       = 1'b0;
            C_flat     = '0;
        end else if (start) begin
            stub_armed = 1'b1;
            stub_dly   = 0;
        end else if (stub_armed && !core_hang) begin
            stub_dly = stub_dly + 1;
            if (stub_dly == 3) begin
                C_flat = mm(A_flat, B_flat);
                done   = 1'b1;
            end else if (stub_dly == 4) begin
                done       = 1'b0;
                stub_armed = 1'b0;
            end
        end
    end

    // Width of the most recent start pulse, in cycles.
    always @(negedge clk) begin
        if (start) begin
            start_run = start_run + 1;
        end else if (start_run != 0) begin
            last_start_len = start_run;
            start_run      = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a negedge, return at a negedge)
    // ------------------------------------------------------------------
    task automatic send_frame(input frame_t fr, input int first, input bit gaps);
        int i = first;
        int guard = 0;
        bit acc;
        while (i < 18 && guard < 1000) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                in_data  = 8'h5A;
            end else begin
                in_valid = 1'b1;
                in_data  = fr[i];
            end
            #1;
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        n_chk++;
        if (i != 18) begin
            n_err++;
            $display("FAIL send_frame: accepted %0d bytes, required 18", i);
        end
    endtask

    task automatic recv_frame(input frame_t exp, input int nbytes, input bit throttle);
        int n = 0;
        int guard = 0;
        bit stalled = 1'b0;
        logic [7:0] held = 8'h00;
        while (n < nbytes && guard < 2000) begin
            out_ready = throttle ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (out_valid) begin
                if (stalled) begin
                    n_chk++;
                    if (out_data !== held) begin
                        n_err++;
                        $display("FAIL stall_hold byte %0d: out_data=%02h required %02h", n, out_data, held);
                    end
                end
                if (out_ready) begin
                    n_chk++;
                    if (out_data !== exp[n]) begin
                        n_err++;
                        $display("FAIL out_byte %0d: out_data=%02h required %02h", n, out_data, exp[n]);
                    end
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held    = out_data;
                end
            end
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        n_chk++;
        if (n != nbytes) begin
            n_err++;
            $display("FAIL recv_frame: got %0d bytes, required %0d", n, nbytes);
        end
    endtask

    task automatic check_idle_after_frame(input string name);
        n_chk++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s_idle: out_valid=%b busy=%b in_ready=%b required 0 0 1",
                     name, out_valid, busy, in_ready);
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (A_flat !== 72'h0 || B_flat !== 72'h0 || start !== 1'b0 || out_valid !== 1'b0 ||
            out_data !== 8'h00 || busy !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state: A=%h B=%h start=%b ov=%b od=%h busy=%b err=%b in_ready=%b required all zero, in_ready=1",
                     A_flat, B_flat, start, out_valid, out_data, busy, err, in_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        frame_t fr, exp;
        for (int i = 0; i < 9; i++) begin
            fr[i]        = (i == 0 || i == 4 || i == 8) ? 8'h01 : 8'h00;
            fr[9+i]      = 8'(i + 1);
            exp[2*i]     = 8'(i + 1);
            exp[2*i + 1] = 8'h00;
        end
        send_frame(fr, 0, 1'b0);
        n_chk++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL identity_busy: busy=%b required 1", busy);
        end
        recv_frame(exp, 18, 1'b0);
        check_idle_after_frame("identity");
        n_chk++;
        if (last_start_len != 2) begin
            n_err++;
            $display("FAIL start_len: start high %0d cycles, required 2", last_start_len);
        end
        n_chk++;
        if (A_flat !== 72'h010000000100000001 || B_flat !== 72'h090807060504030201) begin
            n_err++;
            $display("FAIL operand_hold: A=%h B=%h required 010000000100000001 090807060504030201", A_flat, B_flat);
        end
    endtask

    task automatic test_all_ff();
        frame_t fr, exp;
        for (int i = 0; i < 18; i++) fr[i] = 8'hFF;
        for (int i = 0; i < 9; i++) begin
            exp[2*i]     = 8'h03;
            exp[2*i + 1] = 8'hFA;
        end
        send_frame(fr, 0, 1'b0);
        recv_frame(exp, 18, 1'b0);
        check_idle_after_frame("all_ff");
    endtask

    task automatic test_throttle();
        frame_t fr, exp;
        for (int i = 0; i < 9; i++) begin
            fr[i]        = (i == 0 || i == 4 || i == 8) ? 8'h01 : 8'h00;
            fr[9+i]      = 8'(8'h10 + i);
            exp[2*i]     = 8'(8'h10 + i);
            exp[2*i + 1] = 8'h00;
        end
        send_frame(fr, 0, 1'b0);
        recv_frame(exp, 18, 1'b1);
        check_idle_after_frame("throttle");
    endtask

    task automatic test_timeout();
        frame_t fr, exp;
        int w = 0;
        int guard = 0;
        for (int i = 0; i < 9; i++) begin
            fr[i]        = (i == 0 || i == 4 || i == 8) ? 8'h01 : 8'h00;
            fr[9+i]      = 8'(i + 1);
            exp[2*i]     = 8'(i + 1);
            exp[2*i + 1] = 8'h00;
        end
        core_hang = 1'b1;
        send_frame(fr, 0, 1'b0);
        while (start && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        while (!err && w < 600) begin
            w++;
            @(negedge clk);
        end
        n_chk++;
        if (w != 255) begin
            n_err++;
            $display("FAIL timeout_cycles: err after %0d WAIT cycles, required 255", w);
        end
        n_chk++;
        if (err !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_state: err=%b in_ready=%b busy=%b out_valid=%b required 1 1 0 0",
                     err, in_ready, busy, out_valid);
        end
        core_hang = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (err !== 1'b1) begin
            n_err++;
            $display("FAIL err_sticky: err=%b required 1", err);
        end
        in_valid = 1'b1;
        in_data  = fr[0];
        @(negedge clk);
        in_valid = 1'b0;
        n_chk++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL err_clear: err=%b busy=%b required 0 1", err, busy);
        end
        send_frame(fr, 1, 1'b0);
        recv_frame(exp, 18, 1'b0);
        check_idle_after_frame("after_timeout");
    endtask

    task automatic test_reset_midframe();
        frame_t fr, exp, fr2, exp2;
        for (int i = 0; i < 9; i++) begin
            fr[i]         = (i == 0 || i == 4 || i == 8) ? 8'h01 : 8'h00;
            fr[9+i]       = 8'(i + 1);
            exp[2*i]      = 8'(i + 1);
            exp[2*i + 1]  = 8'h00;
            fr2[i]        = fr[i];
            fr2[9+i]      = 8'(8'h21 + i);
            exp2[2*i]     = 8'(8'h21 + i);
            exp2[2*i + 1] = 8'h00;
        end
        send_frame(fr, 0, 1'b0);
        recv_frame(exp, 5, 1'b0);
        rst = 1'b1;
        #1;
        n_chk++;
        if (A_flat !== 72'h0 || B_flat !== 72'h0 || start !== 1'b0 || out_valid !== 1'b0 ||
            out_data !== 8'h00 || busy !== 1'b0 || err !== 1'b0) begin
            n_err++;
            $display("FAIL midframe_reset: A=%h B=%h start=%b ov=%b od=%h busy=%b err=%b required all zero",
                     A_flat, B_flat, start, out_valid, out_data, busy, err);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_quiet: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
        send_frame(fr2, 0, 1'b0);
        recv_frame(exp2, 18, 1'b0);
        check_idle_after_frame("post_reset");
    endtask

    task automatic test_gaps();
        frame_t fr, exp;
        for (int i = 0; i < 9; i++) begin
            fr[i]        = 8'(i + 1);
            fr[9+i]      = (i == 0 || i == 4 || i == 8) ? 8'h01 : 8'h00;
            exp[2*i]     = 8'(i + 1);
            exp[2*i + 1] = 8'h00;
        end
        send_frame(fr, 0, 1'b1);
        n_chk++;
        if (A_flat !== 72'h090807060504030201 || B_flat !== 72'h010000000100000001) begin
            n_err++;
            $display("FAIL gaps_operands: A=%h B=%h required 090807060504030201 010000000100000001", A_flat, B_flat);
        end
        recv_frame(exp, 18, 1'b1);
        check_idle_after_frame("gaps");
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_identity();
        test_all_ff();
        test_throttle();
        test_timeout();
        test_reset_midframe();
        test_gaps();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul_io_ctrl.md
MATMUL_IO_CTRL -- requirements
Module: matmul_io_ctrl

Interface
REQ-001 SHALL provide parameter START_LEN, default 2, width in cycles of the start pulse driven to the matmul core.
REQ-002 SHALL provide parameter WAIT_TIMEOUT, default 255, the maximum number of WAIT cycles before aborting.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_data  input  8  host operand byte.
REQ-006 SHALL have port in_valid  input  1  in_data valid.
REQ-007 SHALL have port in_ready  output  1  controller accepts in_data this cycle.
REQ-008 SHALL have port out_data  output  8  result byte to host.
REQ-009 SHALL have port out_valid  output  1  out_data valid.
REQ-010 SHALL have port out_ready  input  1  host accepts out_data.
REQ-011 SHALL have port A_flat  output  72  to core, element k in bits [8k+7:8k].
REQ-012 SHALL have port B_flat  output  72  to core, same packing as A_flat.
REQ-013 SHALL have port start  output  1  to core.
REQ-014 SHALL have port C_flat  input  144  from core, element k in bits [16k+15:16k].
REQ-015 SHALL have port done  input  1  from core.
REQ-016 SHALL have port busy  output  1  frame in progress.
REQ-017 SHALL have port err  output  1  sticky timeout flag.

Function
REQ-018 SHALL implement FSM states LOAD, START, WAIT, SEND; reset state LOAD.
REQ-019 In LOAD, SHALL drive in_ready=1; a byte is accepted when in_valid && in_ready; in all other states in_ready=0 and in_data is ignored.
REQ-020 SHALL use a 5-bit byte index k: accepted bytes 0-8 write A_flat[8k+7:8k], bytes 9-17 write B_flat[8(k-9)+7:8(k-9)]; k increments per accepted byte.
REQ-021 On acceptance of byte 17, SHALL clear k and enter START on the next edge; idle in_valid cycles SHALL NOT advance k.
REQ-022 In START, SHALL drive start=1 for exactly START_LEN consecutive cycles, then enter WAIT; start=0 in all other states.
REQ-023 In WAIT, SHALL set an internal done_seen flag when done=1, and SHALL capture C_flat into a 144-bit result register on the first edge where done_seen=1 and done=0, then enter SEND.
REQ-024 In WAIT, SHALL count cycles; if the count reaches WAIT_TIMEOUT without capture, SHALL set err=1, discard the frame, and return to LOAD.
REQ-025 In SEND, SHALL drive out_valid=1 and out_data = result[8j+7:8j] for byte index j=0..17 (little-endian per 16-bit element, element 0 first).
REQ-026 out_data SHALL remain stable while out_valid && !out_ready; j advances only on out_valid && out_ready.
REQ-027 After byte 17 is accepted, SHALL clear j, deassert out_valid on the next cycle, and return to LOAD.
REQ-028 A_flat and B_flat SHALL hold their values outside LOAD and until overwritten by the next frame.
REQ-029 busy SHALL be 1 when state != LOAD or k != 0.
REQ-030 err SHALL remain 1 until byte 0 of the next frame is accepted, which clears it in the same edge.
REQ-031 SHALL perform no arithmetic on operands; results pass through unmodified (16-bit wrap occurs in the core).

Reset
REQ-032 On rst=1, SHALL asynchronously set state=LOAD, k=j=0, the WAIT counter=0, done_seen=0, A_flat=B_flat=0, result=0, start=0, out_valid=0, out_data=0, err=0, busy=0.
REQ-033 rst asserted mid-frame (any state) SHALL abort the frame with no further output bytes; after release the first accepted byte is byte 0.

Verification
REQ-034 A=identity (bytes 01 00 00 00 01 00 00 00 01), B=01..09 -> out bytes 01 00 02 00 03 00 ... 09 00; start high exactly 2 cycles.
REQ-035 All 18 input bytes 0xFF -> every output element 0xFA03 (bytes 03 FA repeated 9 times).
REQ-036 Random out_ready throttling during SEND -> out_data stable while stalled; exactly 18 bytes are delivered, in order.
REQ-037 Core stub holding done=0 -> err=1 after 255 WAIT cycles, state LOAD, in_ready=1; next byte 0 accepted -> err=0.
REQ-038 rst pulsed after 5 output bytes -> all outputs zero; a new full frame yields correct results from byte 0.
REQ-039 in_valid with random gaps during LOAD -> A_flat/B_flat match the input sequence; no byte skipped or duplicated.
